// File: rtl/tb_sim_ctrl.sv
// Simulation sequencer: streams the test image into byte memory, holds the core
// in reset, runs it, and latches a sticky done/pass/fail result from tohost or timeout.
module tb_sim_ctrl #(
    parameter int          AW          = 18,
    parameter int          RST_HOLD    = 4,
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          start,
    input  logic [AW-1:0] load_len,
    input  logic [31:0]   timeout_max,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          core_rstn,
    input  logic          mon_valid,
    input  logic [31:0]   mon_addr,
    input  logic [31:0]   mon_data,
    output logic [2:0]    state,
    output logic          done,
    output logic          pass,
    output logic          timed_out,
    output logic [30:0]   fail_code
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] len_q, len_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [31:0]   tmax_q, tmax_d;
    logic          ld_ready_q, ld_ready_d;
    logic          core_rstn_q, core_rstn_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          to_q, to_d;
    logic [30:0]   fail_q, fail_d;

    logic start_ok, handshake, last_byte, hold_end, tohost_hit, timeout_hit;

    always_comb begin
        start_ok    = start && (state_q == S_IDLE || state_q == S_DONE);
        handshake   = (state_q == S_LOAD) && ld_valid;
        last_byte   = handshake && (addr_q == len_q - AW'(1));
        hold_end    = (state_q == S_HOLD) && (hold_q == HW'(RST_HOLD - 1));
        tohost_hit  = (state_q == S_RUN) && mon_valid && (mon_addr == TOHOST_ADDR)
                      && (mon_data != 32'd0);
        timeout_hit = (state_q == S_RUN) && (tmax_q != 32'd0) && (cyc_q == tmax_q - 32'd1);
    end

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = (load_len == '0) ? S_HOLD : S_LOAD;
            S_LOAD:         if (last_byte) state_d = S_HOLD;
            S_HOLD:         if (hold_end) state_d = S_RUN;
            S_RUN:          if (tohost_hit || timeout_hit) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Counters, result capture and registered outputs
    always_comb begin
        addr_d      = addr_q;
        len_d       = len_q;
        tmax_d      = tmax_q;
        done_d      = done_q;
        pass_d      = pass_q;
        to_d        = to_q;
        fail_d      = fail_q;
        hold_d      = (state_q == S_HOLD) ? hold_q + HW'(1) : '0;
        cyc_d       = (state_q == S_RUN) ? cyc_q + 32'd1 : 32'd0;
        ld_ready_d  = (state_d == S_LOAD);
        core_rstn_d = (state_d == S_RUN);

        if (start_ok) begin
            addr_d = '0;
            len_d  = load_len;
            tmax_d = timeout_max;
            done_d = 1'b0;
            pass_d = 1'b0;
            to_d   = 1'b0;
            fail_d = '0;
        end
        if (handshake) addr_d = addr_q + AW'(1);
        // A tohost hit on the final timeout cycle takes precedence over the timeout.
        if (tohost_hit) begin
            done_d = 1'b1;
            pass_d = (mon_data == 32'd1);
            fail_d = (mon_data == 32'd1) ? 31'd0 : mon_data[31:1];
        end else if (timeout_hit) begin
            done_d = 1'b1;
            to_d   = 1'b1;
            pass_d = 1'b0;
            fail_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            addr_q      <= '0;
            len_q       <= '0;
            hold_q      <= '0;
            cyc_q       <= '0;
            tmax_q      <= '0;
            ld_ready_q  <= 1'b0;
            core_rstn_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            to_q        <= 1'b0;
            fail_q      <= '0;
        end else begin
            addr_q      <= addr_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            cyc_q       <= cyc_d;
            tmax_q      <= tmax_d;
            ld_ready_q  <= ld_ready_d;
            core_rstn_q <= core_rstn_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            to_q        <= to_d;
            fail_q      <= fail_d;
        end
    end

    // Output logic; write port is combinational so a byte lands the cycle it is offered.
    always_comb begin
        ld_ready  = ld_ready_q;
        mem_we    = ld_ready_q && ld_valid;
        mem_wdata = ld_ready_q ? ld_data : 8'd0;
        mem_addr  = addr_q;
        core_rstn = core_rstn_q;
        state     = state_q;
        done      = done_q;
        pass      = pass_q;
        timed_out = to_q;
        fail_code = fail_q;
    end

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Bench for tb_sim_ctrl: directed scenarios plus random runs, checked every cycle
// against a phase/countdown model of the sequencer.
module tb_tb_sim_ctrl;

    localparam int          AW       = 18;
    localparam int          RST_HOLD = 4;
    localparam logic [31:0] TOHOST   = 32'h8000_1000;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] load_len = '0;
    logic [31:0]   timeout_max = '0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = 8'hA5;
    logic          mon_valid = 1'b0;
    logic [31:0]   mon_addr = '0;
    logic [31:0]   mon_data = '0;
    logic          ld_ready, mem_we, core_rstn, done, pass, timed_out;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [2:0]    state;
    logic [30:0]   fail_code;

    tb_sim_ctrl #(.AW(AW), .RST_HOLD(RST_HOLD), .TOHOST_ADDR(TOHOST)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .load_len(load_len),
        .timeout_max(timeout_max), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rstn(core_rstn), .mon_valid(mon_valid),
        .mon_addr(mon_addr), .mon_data(mon_data), .state(state), .done(done),
        .pass(pass), .timed_out(timed_out), .fail_code(fail_code)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Model: phase 0..4 follows the documented state numbering; loading counts bytes,
    // hold counts down, run counts elapsed cycles.
    int          m_ph = 0;
    int          m_loaded = 0;
    int          m_need = 0;
    int          m_hold_left = 0;
    longint      m_run = 0;
    longint      m_tmax = 0;
    bit          m_done = 0, m_pass = 0, m_to = 0;
    logic [30:0] m_fail = '0;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_ph <= 0; m_loaded <= 0; m_done <= 0; m_pass <= 0; m_to <= 0; m_fail <= '0;
        end else begin
            case (m_ph)
                0, 4: if (start) begin
                    m_done <= 0; m_pass <= 0; m_to <= 0; m_fail <= '0;
                    m_loaded <= 0; m_tmax <= longint'(timeout_max);
                    if (load_len == 0) begin m_ph <= 2; m_hold_left <= RST_HOLD; end
                    else begin m_ph <= 1; m_need <= int'(load_len); end
                end
                1: if (ld_valid) begin
                    m_loaded <= m_loaded + 1;
                    if (m_loaded + 1 == m_need) begin m_ph <= 2; m_hold_left <= RST_HOLD; end
                end
                2: if (m_hold_left == 1) begin m_ph <= 3; m_run <= 0; end
                   else m_hold_left <= m_hold_left - 1;
                3: if (mon_valid && mon_addr == TOHOST && mon_data != 0) begin
                    m_ph <= 4; m_done <= 1; m_pass <= (mon_data == 1);
                    m_fail <= (mon_data == 1) ? 31'd0 : mon_data[31:1];
                end else if (m_tmax != 0 && m_run + 1 == m_tmax) begin
                    m_ph <= 4; m_done <= 1; m_to <= 1; m_pass <= 0; m_fail <= '0;
                end else m_run <= m_run + 1;
                default: m_ph <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge CLK) begin
        if (cyc > 0) begin
            chk("ctl", {57'd0, state, core_rstn, ld_ready, mem_we, done, pass, timed_out},
                {57'd0, 3'(m_ph), m_ph == 3, m_ph == 1, (m_ph == 1) && ld_valid,
                 m_done, m_pass, m_to});
            chk("data", {7'd0, mem_addr, mem_wdata, fail_code},
                {7'd0, AW'(m_loaded), (m_ph == 1) ? ld_data : 8'h00, m_fail});
        end
    end

    // Memory image as written by the DUT, plus write bookkeeping
    logic [7:0] cap [0:255];
    int         last_we_cyc = 0;
    int         we_cnt = 0;
    always @(posedge CLK) if (mem_we) cap[mem_addr[7:0]] <= mem_wdata;
    always @(negedge CLK) if (mem_we) begin last_we_cyc <= cyc; we_cnt <= we_cnt + 1; end

    logic [7:0] lb [0:15];
    int run_cyc = 0;
    int done_cyc = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int len, input int tmax);
        start = 1'b1; load_len = AW'(len); timeout_max = 32'(tmax);
        step();
        start = 1'b0;
    endtask

    // gap_pct >= 100 means strictly alternating gap/valid cycles
    task automatic load_n(input int n, input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 500) begin
            if (gap_pct >= 100) ld_valid = (guard % 2 == 1);
            else ld_valid = ($urandom_range(0, 99) >= gap_pct);
            ld_data = ld_valid ? lb[i] : 8'($urandom);
            step();
            guard++;
            if (ld_valid) i++;
        end
        ld_valid = 1'b0;
        chk("load_bound", 64'(i), 64'(n));
    endtask

    task automatic wait_rstn(input int limit);
        int k = 0;
        while (!core_rstn && k < limit) begin step(); k++; end
        run_cyc = cyc;
        chk("wait_run", 64'(core_rstn), 64'd1);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin step(); k++; end
        done_cyc = cyc;
        chk("wait_done", 64'(done), 64'd1);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mon_valid = 1'b1; mon_addr = a; mon_data = d;
        step();
        mon_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int we_before;
        int len, tmax, k;
        repeat (3) step();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_outs", {58'd0, core_rstn, ld_ready, mem_we, done, pass, timed_out}, 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        RSTn = 1'b1;
        step();

        // Directed load with gaps, then pass
        lb[0] = 8'd11; lb[1] = 8'd22; lb[2] = 8'd33; lb[3] = 8'd44;
        do_start(4, 0);
        chk("load_state", 64'(state), 64'd1);
        load_n(4, 100);
        wait_rstn(20);
        chk("hs_to_rstn", 64'(run_cyc - last_we_cyc), 64'd5);
        chk("mem_img", {32'd0, cap[0], cap[1], cap[2], cap[3]}, 64'h0B16_212C);
        step(); step();
        store(TOHOST + 32'd4, 32'd5);
        store(32'h1234, 32'd1);
        store(TOHOST, 32'd1);
        chk("pass_res", {60'd0, done, pass, timed_out, core_rstn}, 64'b1100);
        chk("pass_fc", 64'(fail_code), 64'd0);

        // Ignored zero/other-address stores, then failing code
        lb[0] = 8'h5A; lb[1] = 8'hC3;
        do_start(2, 0);
        chk("restart_clr", {61'd0, done, pass, timed_out}, 64'd0);
        load_n(2, 30);
        wait_rstn(20);
        store(TOHOST, 32'd0);
        store(TOHOST + 32'd4, 32'd7);
        chk("no_end", 64'(done), 64'd0);
        store(TOHOST, 32'd7);
        chk("fail_res", {61'd0, done, pass, timed_out}, 64'b100);
        chk("fail_fc", 64'(fail_code), 64'd3);

        // load_len=0 with timeout; starts during HOLD and RUN are ignored
        we_before = we_cnt;
        do_start(0, 10);
        chk("skip_load", 64'(state), 64'd2);
        do_start(7, 3);
        wait_rstn(20);
        do_start(7, 3);
        wait_done(40);
        chk("to_lat", 64'(done_cyc - run_cyc), 64'd10);
        chk("to_res", {61'd0, done, pass, timed_out}, 64'b101);
        chk("no_we", 64'(we_cnt - we_before), 64'd0);

        // tohost on the final timeout cycle wins
        do_start(0, 10);
        wait_rstn(20);
        repeat (9) step();
        store(TOHOST, 32'd1);
        chk("tie_lat", 64'(cyc - run_cyc), 64'd10);
        chk("tie_res", {61'd0, done, pass, timed_out}, 64'b110);

        // Reset mid-load, then full reload from address 0
        for (int i = 0; i < 8; i++) lb[i] = 8'(8'h70 + i);
        do_start(8, 0);
        load_n(2, 0);
        RSTn = 1'b0;
        #1;
        chk("mid_rst", {59'd0, state, ld_ready, core_rstn}, 64'd0);
        step();
        RSTn = 1'b1;
        step();
        for (int i = 0; i < 8; i++) lb[i] = 8'(8'h90 + i);
        do_start(8, 0);
        load_n(8, 30);
        chk("reload0", 64'(cap[0]), 64'h90);
        chk("reload7", 64'(cap[7]), 64'h97);
        wait_rstn(20);
        store(TOHOST, 32'd1);

        // Random runs
        for (int it = 0; it < 25; it++) begin
            len  = $urandom_range(0, 12);
            tmax = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
            for (int i = 0; i < 16; i++) lb[i] = 8'($urandom);
            do_start(len, tmax);
            load_n(len, 35);
            wait_rstn(20);
            k = 0;
            while (!done && k < 80) begin
                mon_valid = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 3))
                    0, 1:    mon_addr = TOHOST;
                    2:       mon_addr = TOHOST + 32'd4;
                    default: mon_addr = $urandom;
                endcase
                case ($urandom_range(0, 5))
                    0, 1:    mon_data = 32'd0;
                    2:       mon_data = 32'd1;
                    default: mon_data = $urandom;
                endcase
                if (k == 79) begin mon_valid = 1'b1; mon_addr = TOHOST; mon_data = 32'd1; end
                step();
                k++;
            end
            mon_valid = 1'b0;
            chk("rand_done", 64'(done), 64'd1);
            repeat ($urandom_range(0, 3)) step();
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
